fs_serial: RTL and testbench

Bit-serial full-subtractor datapath. It computes d = a − b − bi over WIDTH-bit operands, one bit per clock, LSB first. The per-bit cell is the subtract-direction counterpart of the full-adder cell in this library: d_i = a_i ^ b_i ^ br and br' = (~a_i & b_i) | (~(a_i ^ b_i) & br). Operands load through a start/busy/done handshake, so the block trades WIDTH cycles of latency for a single-bit datapath.

---
 rtl/fs_serial.sv | 108 ++++++++++
 tb/tb_fs_serial.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fs_serial.sv
// fs_serial: bit-serial full subtractor, d = a - b - bi, LSB first.
// One operand bit is processed per clock through a single borrow cell.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   SHIFT | processing one bit per cycle, busy = 1
//   DONE  | result newly presented, done = 1 for one cycle
module fs_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ov
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic             x;
  logic             br_nxt;

  // Single-bit borrow cell working on the current LSBs.
  always_comb begin
    x      = sa[0] ^ sb[0] ^ br;
    br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  end

  // Sequencer plus shift datapath; result registers load only on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      d     <= '0;
      bo    <= 1'b0;
      ov    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bi;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          br <= br_nxt;
          sr <= {x, sr[WIDTH-1:1]};
          sa <= sa >> 1;
          sb <= sb >> 1;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            d     <= {x, sr[WIDTH-1:1]};
            bo    <= br_nxt;
            ov    <= (a_msb ^ b_msb) & (a_msb ^ x);
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status decodes straight from the state register.
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_fs_serial.sv
// tb_fs_serial: randomized self-checking bench for fs_serial (WIDTH = 8).
module tb_fs_serial;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             ov;

  int n_tests;
  int n_fail;

  logic [WIDTH-1:0] prev_d;
  logic             prev_bo;
  logic             prev_ov;

  fs_serial #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bi   (bi),
    .busy (busy),
    .done (done),
    .d    (d),
    .bo   (bo),
    .ov   (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for d/bo, signed for ov.
  task automatic model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                       input logic tbi, output logic [WIDTH-1:0] ed,
                       output logic ebo, output logic eov);
    int r;
    int rs;
    r   = int'(ta) - int'(tb_) - int'(tbi);
    ed  = r[WIDTH-1:0];
    ebo = (r < 0);
    rs  = int'($signed(ta)) - int'($signed(tb_)) - int'(tbi);
    eov = (rs < -(1 << (WIDTH-1))) || (rs > (1 << (WIDTH-1)) - 1);
  endtask

  // One full operation; with disturb set, inputs and start toggle while busy.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic tbi, input bit disturb);
    logic [WIDTH-1:0] ed;
    logic ebo, eov;
    int busy_n;
    bit seen;
    model(ta, tb_, tbi, ed, ebo, eov);
    @(negedge clk);
    a = ta; b = tb_; bi = tbi; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < WIDTH + 4 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_n++;
        check("hold_d", {24'd0, d}, {24'd0, prev_d});
        check("hold_flags", {30'd0, bo, ov}, {30'd0, prev_bo, prev_ov});
        if (disturb) begin
          a     = WIDTH'($urandom);
          b     = WIDTH'($urandom);
          bi    = 1'($urandom);
          start = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    check("busy_cycles", busy_n, WIDTH);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("d", {24'd0, d}, {24'd0, ed});
    check("bo", {31'd0, bo}, {31'd0, ebo});
    check("ov", {31'd0, ov}, {31'd0, eov});
    @(posedge clk); #1;
    check("done_pulse_end", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    prev_d  = ed;
    prev_bo = ebo;
    prev_ov = eov;
  endtask

  initial begin
    int done_times[$];
    int cyc;
    logic [WIDTH-1:0] ed;
    logic ebo, eov;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
    prev_d = '0; prev_bo = 1'b0; prev_ov = 1'b0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_d", {24'd0, d}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases from the plan.
    run_op(8'h05, 8'h03, 1'b0, 1'b0);
    check("dir_05_03", {24'd0, d}, 32'h02);
    run_op(8'h03, 8'h05, 1'b0, 1'b0);
    check("dir_03_05", {23'd0, d, bo}, {23'd0, 8'hFE, 1'b1});
    run_op(8'h80, 8'h01, 1'b0, 1'b0);
    check("dir_80_01", {23'd0, d, ov}, {23'd0, 8'h7F, 1'b1});
    run_op(8'h00, 8'h00, 1'b1, 1'b0);
    check("dir_00_00_bi", {22'd0, d, bo, ov}, {22'd0, 8'hFF, 1'b1, 1'b0});

    // Asynchronous reset mid-cycle clears outputs with no clock edge.
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_rst_d", {24'd0, d}, 32'd0);
    check("async_rst_flags", {29'd0, busy, done, bo, ov}, 32'd0);
    prev_d = '0; prev_bo = 1'b0; prev_ov = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Random operands, some with inputs/start disturbed while busy.
    for (int k = 0; k < 40; k++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), bit'(k % 3 == 0));
    end

    // Start held high: one result every WIDTH + 2 cycles.
    @(negedge clk);
    a = 8'h5A; b = 8'hC3; bi = 1'b1; start = 1'b1;
    model(a, b, bi, ed, ebo, eov);
    for (cyc = 0; cyc < 5 * (WIDTH + 2) + 2; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        done_times.push_back(cyc);
        check("cont_d", {24'd0, d}, {24'd0, ed});
      end
    end
    start = 1'b0;
    check("cont_pulses", done_times.size(), 5);
    for (int j = 1; j < done_times.size(); j++)
      check("cont_period", done_times[j] - done_times[j-1], WIDTH + 2);
    repeat (WIDTH + 3) @(posedge clk);
    #1;
    prev_d = ed; prev_bo = ebo; prev_ov = eov;

    // Reset mid-operation: prior result 0x02, abort at bit 4.
    run_op(8'h05, 8'h03, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h03; b = 8'h05; bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_d", {24'd0, d}, 32'd0);
    check("midrst_flags", {29'd0, busy, done, bo, ov}, 32'd0);
    prev_d = '0; prev_bo = 1'b0; prev_ov = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < WIDTH + 4; j++) begin
      @(posedge clk); #1;
      check("midrst_no_done", {30'd0, busy, done}, 32'd0);
    end
    run_op(8'h03, 8'h05, 1'b0, 1'b0);
    check("midrst_after", {23'd0, d, bo}, {23'd0, 8'hFE, 1'b1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
